fpu_rr_scheduler: RTL and testbench
===================================

# fpu_rr_scheduler

Round-robin issue scheduler that shares one single-precision floating-point functional unit (adder/subtractor, 24-bit multiplier, divider, normalizer) between two requesters. It arbitrates, launches one operation at a time with a start pulse and registered operands, times the op-dependent fixed latency, and captures the result. It returns the result to the originating requester over a valid/ready response channel. The block sits between the integer-side issue logic and the FP ALU datapath.

## Interface
- LAT_ADD, 2: FU latency in cycles for add/sub, from the fu_start cycle to the cycle fu_result is valid. Minimum 1.
- LAT_MUL, 3: FU latency for multiply. Minimum 1.
- LAT_DIV, 6: FU latency for divide. Minimum 1, maximum 15.
- clk  in  1  Clock. All state is updated on its rising edge.
- rst  in  1  Reset. Synchronous, active-high.
- reqN_valid  in  1  Request valid, for N = 0 and 1.
- reqN_ready  out  1  Request accepted this cycle.
- reqN_op  in  2  Operation: 00 add, 01 sub, 10 mul, 11 div.
- reqN_a, reqN_b  in  32  IEEE-754 single-precision operands.
- fu_start  out  1  One-cycle launch pulse to the FU.
- fu_op  out  2  Registered op code.
- fu_a, fu_b  out  32  Registered operands. Held stable from fu_start until capture.
- fu_result  in  32  FU result. Sampled only in the capture cycle.
- rspN_valid  out  1  Result valid for requester N.
- rspN_result  out  32  Result.
- rspN_ready  in  1  Requester N takes the result.

## Operation
- FSM states: IDLE, ISSUE, BUSY, DONE.
- IDLE:
  - Grant goes to a requester with valid asserted. If both are valid, grant goes to the requester not granted last; last_grant resets to 1, so req0 wins first.
  - reqN_ready = (state==IDLE) & grant==N. It is combinational from the valids.
  - On handshake, register op, operands, and owner tag. Go to ISSUE.
- ISSUE: fu_start=1 for exactly one cycle. Load cnt with the latency for the op (sub uses LAT_ADD). Go to BUSY.
- BUSY: cnt decrements every cycle. In the cycle cnt==1, capture fu_result into the result register and go to DONE.
- DONE:
  - rsp<owner>_valid=1 and rsp<owner>_result=the captured value. The other rsp valid stays 0.
  - Hold until rsp<owner>_ready. Then go to IDLE and update last_grant.
- Requesters must hold reqN_valid and operands stable until ready. Dropping valid before ready is allowed; no request is then issued.
- The scheduler never inspects or modifies operand or result bits. Exception: the bypass in Configuration.
- A request from the non-owner is stalled while the scheduler is in ISSUE, BUSY, or DONE.
- cnt is 4 bits wide and never wraps. On reaching 1 the FSM leaves BUSY.

## Timing
- Reset values: all reqN_ready=0 while rst is high; fu_start=0; fu_op=0; fu_a=fu_b=0; rspN_valid=0; rspN_result=0; state IDLE; last_grant=1; cnt=0.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. The in-flight result is discarded; a late FU result is ignored.
- Request handshake at cycle T:
  - fu_start at T+1.
  - FU result valid at T+1+LAT; it is captured at the end of that cycle.
  - rsp_valid from T+2+LAT.
- With rsp_ready held high, rsp_valid is high for exactly 1 cycle and the next request can be accepted at T+3+LAT.
- Simultaneous events:
  - rsp handshake and a new request valid in the same cycle: the new request waits one cycle (accepted in IDLE at the next cycle).
  - Both requests valid in IDLE: exactly one ready is asserted.

## Configuration
- FPU_SCHED_ZERO_BYPASS_EN defined:
  - Applies to mul with either operand having bits[30:0]==0, and to div with reqN_a[30:0]==0 and reqN_b[30:0]!=0.
  - These ops skip ISSUE and BUSY: no fu_start is issued, and the state goes IDLE→DONE directly.
  - The result is {a[31]^b[31], 31'b0}, and rsp_valid rises at T+1.
- Not defined: every op goes through the FU with the standard latency.

## Test plan
- Single add: req0 a=0x3F800000, b=0x40000000, op 00, handshake at T; FU model returns 0x40400000. Required: fu_start at T+1 only; rsp0_valid at T+4 with rsp0_result=0x40400000; rsp1_valid stays 0.
- Contention: both valid at the same cycle out of reset, req0 op mul, req1 op div. Required: req0 granted first; rsp0 at T+5; req1 granted at T+6 (rsp0_ready held high); rsp1 at T+6+8.
- Backpressure: div with rsp1_ready low for 10 cycles. Required: rsp1_valid and result held stable; no new ready asserted; IDLE one cycle after the ready handshake.
- Reset mid-BUSY: assert rst 2 cycles after fu_start of a div. Required: the next cycle has all outputs at reset values; no rsp_valid afterward, even though the FU model produces a result.
- Fairness: both requesters continuously valid for 20 ops. Required: grants strictly alternate 0,1,0,1…
- Bypass (macro defined): req0 mul a=0x80000000, b=0x40400000. Required: no fu_start; rsp0_valid at T+1 with result 0x80000000. Without the macro, fu_start at T+1 and the result comes from the FU.

Source files
------------

// File: rtl/fpu_rr_scheduler.sv
// Round-robin issue scheduler sharing one FP functional unit between two requesters.
// Optional zero-operand mul/div bypass enabled by defining FPU_SCHED_ZERO_BYPASS_EN.
module fpu_rr_scheduler #(
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        fu_start,
  output logic [1:0]  fu_op,
  output logic [31:0] fu_a,
  output logic [31:0] fu_b,
  input  logic [31:0] fu_result,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_result,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_result,
  input  logic        rsp1_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_e;

  state_e      state_q;
  logic        lastGrant_q;
  logic        owner_q;
  logic        fuStart_q;
  logic        rspValid_q;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] result_q;
  logic [3:0]  cnt_q;

  logic        anyValid_d;
  logic        grant_d;
  logic [1:0]  selOp_d;
  logic [31:0] selA_d;
  logic [31:0] selB_d;
  logic [3:0]  lat_d;
  logic        bypass_d;
  logic        ownerReady_d;

  // On a tie the requester that was not served last wins.
  always_comb begin
    anyValid_d = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_d = ~lastGrant_q;
    end else begin
      grant_d = req1_valid;
    end
    selOp_d = grant_d ? req1_op : req0_op;
    selA_d  = grant_d ? req1_a  : req0_a;
    selB_d  = grant_d ? req1_b  : req0_b;
    case (op_q)
      2'b10:   lat_d = 4'(LAT_MUL);
      2'b11:   lat_d = 4'(LAT_DIV);
      default: lat_d = 4'(LAT_ADD);
    endcase
    ownerReady_d = owner_q ? rsp1_ready : rsp0_ready;
  end

`ifdef FPU_SCHED_ZERO_BYPASS_EN
  assign bypass_d = ((selOp_d == 2'b10) && ((selA_d[30:0] == 31'd0) || (selB_d[30:0] == 31'd0))) ||
                    ((selOp_d == 2'b11) && (selA_d[30:0] == 31'd0) && (selB_d[30:0] != 31'd0));
`else
  assign bypass_d = 1'b0;
`endif

  assign req0_ready = ~rst & (state_q == IDLE) & req0_valid & ~grant_d;
  assign req1_ready = ~rst & (state_q == IDLE) & req1_valid &  grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      owner_q     <= 1'b0;
      fuStart_q   <= 1'b0;
      rspValid_q  <= 1'b0;
      op_q        <= 2'b00;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      result_q    <= 32'd0;
      cnt_q       <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyValid_d) begin
            owner_q <= grant_d;
            op_q    <= selOp_d;
            a_q     <= selA_d;
            b_q     <= selB_d;
            if (bypass_d) begin
              result_q   <= {selA_d[31] ^ selB_d[31], 31'd0};
              rspValid_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              fuStart_q <= 1'b1;
              state_q   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          fuStart_q <= 1'b0;
          cnt_q     <= lat_d;
          state_q   <= BUSY;
        end
        BUSY: begin
          // The FU result is valid in exactly the cycle the count reads 1.
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end
          if (cnt_q <= 4'd1) begin
            result_q   <= fu_result;
            rspValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (ownerReady_d) begin
            rspValid_q  <= 1'b0;
            lastGrant_q <= owner_q;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fu_start    = fuStart_q;
  assign fu_op       = op_q;
  assign fu_a        = a_q;
  assign fu_b        = b_q;
  assign rsp0_valid  = rspValid_q & ~owner_q;
  assign rsp1_valid  = rspValid_q &  owner_q;
  assign rsp0_result = owner_q ? 32'd0 : result_q;
  assign rsp1_result = owner_q ? result_q : 32'd0;

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// Directed bench for fpu_rr_scheduler with a fixed-latency FU model.
// Bypass expectations follow FPU_SCHED_ZERO_BYPASS_EN.
module tb_fpu_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic        fu_start;
  logic [1:0]  fu_op;
  logic [31:0] fu_a, fu_b;
  logic [31:0] fu_result = 32'hDEADBEEF;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] fuAns [4];
  int          fuCnt = 0;
  logic [1:0]  fuOpLat = 2'b00;

  fpu_rr_scheduler #(.LAT_ADD(2), .LAT_MUL(3), .LAT_DIV(6)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .fu_start(fu_start), .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b), .fu_result(fu_result),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_ready(rsp1_ready)
  );

  always #5 clk = ~clk;

  function automatic int latOf(input logic [1:0] op);
    case (op)
      2'b10:   return 3;
      2'b11:   return 6;
      default: return 2;
    endcase
  endfunction

  // FU model: result is driven only in the cycle start+LAT, garbage otherwise.
  always @(posedge clk) begin
    int         nxt;
    logic [1:0] opN;
    nxt = fuCnt;
    opN = fuOpLat;
    if (fu_start) begin
      nxt = latOf(fu_op);
      opN = fu_op;
    end else if (fuCnt > 0) begin
      nxt = fuCnt - 1;
    end
    fuCnt     <= nxt;
    fuOpLat   <= opN;
    fu_result <= (nxt == 1) ? fuAns[opN] : 32'hDEADBEEF;
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int n, input logic v, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic waitRsp(input int n, input int budget, output int steps);
    steps = 0;
    while (((n == 0) ? rsp0_valid : rsp1_valid) !== 1'b1 && steps < budget) begin
      nextCycle();
      steps++;
    end
    if (((n == 0) ? rsp0_valid : rsp1_valid) !== 1'b1) steps = -1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  initial begin
    int steps;
    fuAns[0] = 32'h40400000;
    fuAns[1] = 32'h40400000;
    fuAns[2] = 32'h40C00000;
    fuAns[3] = 32'h40400000;

    $display("[TB] reset values");
    nextCycle();
    nextCycle();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checkOutput("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    checkOutput("rst_fu_start", {31'd0, fu_start}, 32'd0);
    checkOutput("rst_fu_op", {30'd0, fu_op}, 32'd0);
    checkOutput("rst_fu_a", fu_a, 32'd0);
    checkOutput("rst_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    checkOutput("rst_rsp0_result", rsp0_result, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;

    $display("[TB] single add");
    nextCycle();
    applyStimulus(0, 1'b1, 2'b00, 32'h3F800000, 32'h40000000);
    #1;
    checkOutput("add_ready", {30'd0, req0_ready, req1_ready}, 32'd2);
    nextCycle();
    applyStimulus(0, 1'b0, 2'b00, 32'h3F800000, 32'h40000000);
    checkOutput("add_start", {31'd0, fu_start}, 32'd1);
    checkOutput("add_fu_a", fu_a, 32'h3F800000);
    checkOutput("add_fu_b", fu_b, 32'h40000000);
    nextCycle();
    checkOutput("add_start_once", {31'd0, fu_start}, 32'd0);
    nextCycle();
    checkOutput("add_rsp_early", {31'd0, rsp0_valid}, 32'd0);
    nextCycle();
    checkOutput("add_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd2);
    checkOutput("add_rsp_result", rsp0_result, 32'h40400000);
    nextCycle();
    checkOutput("add_rsp_drop", {31'd0, rsp0_valid}, 32'd0);

    $display("[TB] contention");
    doReset();
    nextCycle();
    applyStimulus(0, 1'b1, 2'b10, 32'h40000000, 32'h40400000);
    applyStimulus(1, 1'b1, 2'b11, 32'h40C00000, 32'h40000000);
    #1;
    checkOutput("cont_ready", {30'd0, req0_ready, req1_ready}, 32'd2);
    nextCycle();
    req0_valid = 1'b0;
    #1;
    checkOutput("cont_fu_op", {30'd0, fu_op}, 32'd2);
    checkOutput("cont_stall", {31'd0, req1_ready}, 32'd0);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("cont_rsp0_early", {31'd0, rsp0_valid}, 32'd0);
    nextCycle();
    checkOutput("cont_rsp0_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd2);
    checkOutput("cont_rsp0_result", rsp0_result, 32'h40C00000);
    checkOutput("cont_stall_done", {31'd0, req1_ready}, 32'd0);
    nextCycle();
    checkOutput("cont_req1_grant", {30'd0, req0_ready, req1_ready}, 32'd1);
    nextCycle();
    req1_valid = 1'b0;
    for (int k = 0; k < 6; k++) nextCycle();
    checkOutput("cont_rsp1_early", {31'd0, rsp1_valid}, 32'd0);
    nextCycle();
    checkOutput("cont_rsp1_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd1);
    checkOutput("cont_rsp1_result", rsp1_result, 32'h40400000);

    $display("[TB] backpressure");
    nextCycle();
    rsp1_ready = 1'b0;
    fuAns[3] = 32'h40A00000;
    applyStimulus(1, 1'b1, 2'b11, 32'h41200000, 32'h40000000);
    #1;
    checkOutput("bp_grant", {30'd0, req0_ready, req1_ready}, 32'd1);
    nextCycle();
    req1_valid = 1'b0;
    applyStimulus(0, 1'b1, 2'b00, 32'h3F800000, 32'h3F800000);
    #1;
    checkOutput("bp_stall_issue", {31'd0, req0_ready}, 32'd0);
    for (int k = 0; k < 6; k++) nextCycle();
    checkOutput("bp_rsp_early", {31'd0, rsp1_valid}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      nextCycle();
      checkOutput("bp_hold_valid", {31'd0, rsp1_valid}, 32'd1);
      checkOutput("bp_hold_result", rsp1_result, 32'h40A00000);
      checkOutput("bp_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    end
    rsp1_ready = 1'b1;
    nextCycle();
    checkOutput("bp_released", {31'd0, rsp1_valid}, 32'd0);
    checkOutput("bp_idle_ready", {30'd0, req0_ready, req1_ready}, 32'd2);
    nextCycle();
    req0_valid = 1'b0;
    waitRsp(0, 10, steps);
    checkOutput("bp_drain_lat", 32'(steps), 32'd3);
    checkOutput("bp_drain_result", rsp0_result, 32'h40400000);
    nextCycle();

    $display("[TB] reset mid-busy");
    fuAns[3] = 32'h40000000;
    applyStimulus(0, 1'b1, 2'b11, 32'h40000000, 32'h3F800000);
    #1;
    checkOutput("mid_grant", {31'd0, req0_ready}, 32'd1);
    nextCycle();
    req0_valid = 1'b0;
    checkOutput("mid_start", {31'd0, fu_start}, 32'd1);
    nextCycle();
    nextCycle();
    rst = 1'b1;
    nextCycle();
    checkOutput("mid_fu_op", {30'd0, fu_op}, 32'd0);
    checkOutput("mid_fu_a", fu_a, 32'd0);
    checkOutput("mid_fu_b", fu_b, 32'd0);
    checkOutput("mid_fu_start", {31'd0, fu_start}, 32'd0);
    checkOutput("mid_rsp0_result", rsp0_result, 32'd0);
    checkOutput("mid_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    rst = 1'b0;
    waitRsp(0, 12, steps);
    checkOutput("mid_no_rsp", 32'(steps), 32'hFFFFFFFF);

    $display("[TB] fairness");
    fuAns[0] = 32'h3F800000;
    applyStimulus(0, 1'b1, 2'b00, 32'h3F000000, 32'h3F000000);
    applyStimulus(1, 1'b1, 2'b00, 32'h3E800000, 32'h3E800000);
    #1;
    for (int i = 0; i < 20; i++) begin
      steps = 0;
      while (!(req0_ready || req1_ready) && steps < 10) begin
        nextCycle();
        steps++;
      end
      checkOutput("fair_grant", {30'd0, req0_ready, req1_ready}, (i % 2 == 0) ? 32'd2 : 32'd1);
      if (i > 0) checkOutput("fair_gap", 32'(steps), 32'd4);
      nextCycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    waitRsp(1, 10, steps);
    checkOutput("fair_last_lat", 32'(steps), 32'd3);
    checkOutput("fair_last_result", rsp1_result, 32'h3F800000);
    nextCycle();

    $display("[TB] zero-operand multiply");
    fuAns[2] = 32'h12345678;
    applyStimulus(0, 1'b1, 2'b10, 32'h80000000, 32'h40400000);
    #1;
    checkOutput("byp_grant", {31'd0, req0_ready}, 32'd1);
    nextCycle();
    req0_valid = 1'b0;
`ifdef FPU_SCHED_ZERO_BYPASS_EN
    checkOutput("byp_no_start", {31'd0, fu_start}, 32'd0);
    checkOutput("byp_rsp_valid", {31'd0, rsp0_valid}, 32'd1);
    checkOutput("byp_rsp_result", rsp0_result, 32'h80000000);
    nextCycle();
    checkOutput("byp_rsp_drop", {31'd0, rsp0_valid}, 32'd0);
`else
    checkOutput("byp_start", {31'd0, fu_start}, 32'd1);
    waitRsp(0, 10, steps);
    checkOutput("byp_lat", 32'(steps), 32'd4);
    checkOutput("byp_result", rsp0_result, 32'h12345678);
    nextCycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
